// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the 16-bit nandgame CPU.
//   jmp_flag_t  - jump-condition word {lt, eq, gt}, shared with the condition evaluator
//   alu_ctrl_t  - ALU control bundle {src_mem, u, op1, op0, zx, sw}
//   Instruction bit-position localparams (CI .. GT)
//   seq_state_e - instruction sequencer state encoding
package cpu_pkg;

    // Instruction word bit positions
    localparam int unsigned CI      = 15;
    localparam int unsigned SRC_MEM = 12;
    localparam int unsigned U       = 10;
    localparam int unsigned OP1     = 9;
    localparam int unsigned OP0     = 8;
    localparam int unsigned ZX      = 7;
    localparam int unsigned SW      = 6;
    localparam int unsigned DA      = 5;
    localparam int unsigned DD      = 4;
    localparam int unsigned DM      = 3;
    localparam int unsigned LT      = 2;
    localparam int unsigned EQ      = 1;
    localparam int unsigned GT      = 0;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } jmp_flag_t;

    typedef struct packed {
        logic src_mem;
        logic u;
        logic op1;
        logic op0;
        logic zx;
        logic sw;
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: purely combinational instruction decoder.
// Ports:
//   ir        in  WIDTH  instruction word
//   is_const  out 1      ir[CI]==0, A is loaded with const_val
//   const_val out WIDTH  {1'b0, ir[WIDTH-2:0]}
//   alu_ctrl  out        ALU control fields (taken from ir unconditionally)
//   dst_a/d/m out 1      destination enables, 0 for constant words
//   j         out        jump-condition flags, 0 for constant words
module instr_decode
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] ir,
    output logic             is_const,
    output logic [WIDTH-1:0] const_val,
    output alu_ctrl_t        alu_ctrl,
    output logic             dst_a,
    output logic             dst_d,
    output logic             dst_m,
    output jmp_flag_t        j
);

    // Field extraction; destinations and jump flags only exist for ALU words
    always_comb begin
        is_const         = ~ir[CI];
        const_val        = {1'b0, ir[WIDTH-2:0]};
        alu_ctrl.src_mem = ir[SRC_MEM];
        alu_ctrl.u       = ir[U];
        alu_ctrl.op1     = ir[OP1];
        alu_ctrl.op0     = ir[OP0];
        alu_ctrl.zx      = ir[ZX];
        alu_ctrl.sw      = ir[SW];
        dst_a            = 1'b0;
        dst_d            = 1'b0;
        dst_m            = 1'b0;
        j                = jmp_flag_t'(3'b000);
        if (ir[CI]) begin
            dst_a = ir[DA];
            dst_d = ir[DD];
            dst_m = ir[DM];
            j.lt  = ir[LT];
            j.eq  = ir[EQ];
            j.gt  = ir[GT];
        end else begin
            dst_a = 1'b0;
            dst_d = 1'b0;
            dst_m = 1'b0;
            j     = jmp_flag_t'(3'b000);
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode sequencer and PC owner.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   run                   advance enable, sampled in IDLE and at EXEC completion
//   imem_req/addr         fetch request (held until ack) and address (= pc)
//   imem_ack/rdata        fetch completion and instruction word
//   exec_valid            decoded controls valid (EXEC state)
//   exec_ready            datapath done; take/a_value valid
//   is_const..j           decoded controls, forced to 0 outside EXEC
//   take, a_value         jump decision and jump target
//   pc                    current program counter
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             exec_valid,
    input  logic             exec_ready,
    output logic             is_const,
    output logic [WIDTH-1:0] const_val,
    output alu_ctrl_t        alu_ctrl,
    output logic             dst_a,
    output logic             dst_d,
    output logic             dst_m,
    output jmp_flag_t        j,
    input  logic             take,
    input  logic [WIDTH-1:0] a_value,
    output logic [WIDTH-1:0] pc
);

    seq_state_e       state_r;
    seq_state_e       state_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_s;
    logic [WIDTH-1:0] ir_r;
    logic [WIDTH-1:0] ir_s;
    logic             in_exec_s;

    logic             dec_is_const_s;
    logic [WIDTH-1:0] dec_const_val_s;
    alu_ctrl_t        dec_alu_ctrl_s;
    logic             dec_dst_a_s;
    logic             dec_dst_d_s;
    logic             dec_dst_m_s;
    jmp_flag_t        dec_j_s;

    instr_decode #(.WIDTH(WIDTH)) u_decode (
        .ir        (ir_r),
        .is_const  (dec_is_const_s),
        .const_val (dec_const_val_s),
        .alu_ctrl  (dec_alu_ctrl_s),
        .dst_a     (dec_dst_a_s),
        .dst_d     (dec_dst_d_s),
        .dst_m     (dec_dst_m_s),
        .j         (dec_j_s)
    );

    // State, program counter and instruction register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            pc_r    <= {WIDTH{1'b0}};
            ir_r    <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            ir_r    <= ir_s;
        end
    end

    // Next-state, ir capture and pc update; a constant word never jumps
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        ir_s    = ir_r;
        case (state_r)
            ST_IDLE: begin
                if (run) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    ir_s    = imem_rdata;
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (exec_ready) begin
                    if (take && !dec_is_const_s) begin
                        pc_s = a_value;
                    end else begin
                        pc_s = pc_r + {{(WIDTH-1){1'b0}}, 1'b1};
                    end
                    if (run) begin
                        state_s = ST_FETCH;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_EXEC;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decode from state; decoded controls are masked
    // outside EXEC so the reset value (ir=0, a constant) presents all zeros
    always_comb begin
        in_exec_s  = (state_r == ST_EXEC);
        imem_req   = (state_r == ST_FETCH);
        exec_valid = in_exec_s;
        imem_addr  = pc_r;
        pc         = pc_r;
        if (in_exec_s) begin
            is_const  = dec_is_const_s;
            const_val = dec_const_val_s;
            alu_ctrl  = dec_alu_ctrl_s;
            dst_a     = dec_dst_a_s;
            dst_d     = dec_dst_d_s;
            dst_m     = dec_dst_m_s;
            j         = dec_j_s;
        end else begin
            is_const  = 1'b0;
            const_val = {WIDTH{1'b0}};
            alu_ctrl  = alu_ctrl_t'(6'b000000);
            dst_a     = 1'b0;
            dst_d     = 1'b0;
            dst_m     = 1'b0;
            j         = jmp_flag_t'(3'b000);
        end
    end

endmodule
